// File: rtl/csr_trap_seq_if.sv
// csr_trap_seq_if
// Bundles every request/response signal of csr_trap_seq so the sequencer and
// its neighbours (retire, CSR FU, CSR file, front end) share one port.
//   Commit write : cw_valid/cw_addr/cw_data -> cw_ready
//   Trap request : trap_valid/trap_pc/trap_cause/trap_tval -> trap_ready
//   Mret request : mret_valid -> mret_ready
//   CSR file     : mstatus_i/mtvec_i/mepc_i in, csr_wvalid/csr_waddr/csr_wdata out
//   Front end    : redirect_valid_o/redirect_pc_o, busy_o (issue stall)
// Modports: master = the environment driving requests and CSR state,
//           slave  = the sequencer itself.
interface csr_trap_seq_if #(
  parameter int XLEN = 64
);
  logic            cw_valid;
  logic [11:0]     cw_addr;
  logic [XLEN-1:0] cw_data;
  logic            cw_ready;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic            trap_ready;
  logic            mret_valid;
  logic            mret_ready;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  logic            csr_wvalid;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            busy_o;

  modport master (
    output cw_valid, cw_addr, cw_data,
    output trap_valid, trap_pc, trap_cause, trap_tval,
    output mret_valid,
    output mstatus_i, mtvec_i, mepc_i,
    input  cw_ready, trap_ready, mret_ready,
    input  csr_wvalid, csr_waddr, csr_wdata,
    input  redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  cw_valid, cw_addr, cw_data,
    input  trap_valid, trap_pc, trap_cause, trap_tval,
    input  mret_valid,
    input  mstatus_i, mtvec_i, mepc_i,
    output cw_ready, trap_ready, mret_ready,
    output csr_wvalid, csr_waddr, csr_wdata,
    output redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/csr_trap_seq.sv
// csr_trap_seq
// Owner of the single CSR-file write port. In IDLE it arbitrates between a
// commit-time CSR write (served combinationally, same cycle), a trap and an
// mret. A trap runs mepc -> mcause -> (mtval) -> mstatus writes, redirecting
// to mtvec with the last write; an mret writes mstatus and redirects to mepc.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - csr_trap_seq_if.slave: request handshakes, CSR file values in,
//          CSR write port, redirect pulse and busy stall out
// Parameters:
//   XLEN     - CSR / PC width
//   MTVAL_EN - 1: trap sequence writes mtval, 0: that step is skipped
module csr_trap_seq #(
  parameter int XLEN     = 64,
  parameter bit MTVAL_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  csr_trap_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_T_MEPC    = 3'd1;
  localparam logic [2:0] S_T_MCAUSE  = 3'd2;
  localparam logic [2:0] S_T_MTVAL   = 3'd3;
  localparam logic [2:0] S_T_MSTATUS = 3'd4;
  localparam logic [2:0] S_M_MSTATUS = 3'd5;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] pc_q, cause_q, tval_q;

  logic            cw_ready, trap_ready, mret_ready;
  logic            wvalid, redir_valid;
  logic [11:0]     waddr;
  logic [XLEN-1:0] wdata, redir_pc;
  logic [XLEN-1:0] ms_trap, ms_mret;

  // State register plus the trap operands captured on accept, so the
  // sequence keeps writing consistent values after retire moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state <= state_nxt;
      if (trap_ready) begin
        pc_q    <= bus.trap_pc;
        cause_q <= bus.trap_cause;
        tval_q  <= bus.trap_tval;
      end
    end
  end

  // Arbitration, write-port mux and redirect generation. All strobes are
  // held low while rst is high so a reset cycle never issues a write or an
  // accept, whatever state it interrupts.
  always_comb begin
    state_nxt   = state;
    cw_ready    = 1'b0;
    trap_ready  = 1'b0;
    mret_ready  = 1'b0;
    wvalid      = 1'b0;
    waddr       = '0;
    wdata       = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    ms_trap        = bus.mstatus_i;
    ms_trap[7]     = bus.mstatus_i[3];
    ms_trap[3]     = 1'b0;
    ms_trap[12:11] = 2'b11;

    // Trap return: MIE <= MPIE, MPIE <= 1, MPP <= M.
    ms_mret        = bus.mstatus_i;
    ms_mret[3]     = bus.mstatus_i[7];
    ms_mret[7]     = 1'b1;
    ms_mret[12:11] = 2'b11;

    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (bus.cw_valid) begin
            cw_ready = 1'b1;
            wvalid   = 1'b1;
            waddr    = bus.cw_addr;
            wdata    = bus.cw_data;
          end else if (bus.trap_valid) begin
            trap_ready = 1'b1;
            state_nxt  = S_T_MEPC;
          end else if (bus.mret_valid) begin
            mret_ready = 1'b1;
            state_nxt  = S_M_MSTATUS;
          end
        end
        S_T_MEPC: begin
          wvalid    = 1'b1;
          waddr     = A_MEPC;
          wdata     = {pc_q[XLEN-1:1], 1'b0};
          state_nxt = S_T_MCAUSE;
        end
        S_T_MCAUSE: begin
          wvalid    = 1'b1;
          waddr     = A_MCAUSE;
          wdata     = cause_q;
          state_nxt = MTVAL_EN ? S_T_MTVAL : S_T_MSTATUS;
        end
        S_T_MTVAL: begin
          wvalid    = 1'b1;
          waddr     = A_MTVAL;
          wdata     = tval_q;
          state_nxt = S_T_MSTATUS;
        end
        S_T_MSTATUS: begin
          wvalid      = 1'b1;
          waddr       = A_MSTATUS;
          wdata       = ms_trap;
          redir_valid = 1'b1;
          redir_pc    = {bus.mtvec_i[XLEN-1:2], 2'b00};
          state_nxt   = S_IDLE;
        end
        S_M_MSTATUS: begin
          wvalid      = 1'b1;
          waddr       = A_MSTATUS;
          wdata       = ms_mret;
          redir_valid = 1'b1;
          redir_pc    = bus.mepc_i;
          state_nxt   = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.cw_ready         = cw_ready;
  assign bus.trap_ready       = trap_ready;
  assign bus.mret_ready       = mret_ready;
  assign bus.csr_wvalid       = wvalid;
  assign bus.csr_waddr        = waddr;
  assign bus.csr_wdata        = wdata;
  assign bus.redirect_valid_o = redir_valid;
  assign bus.redirect_pc_o    = redir_pc;
  assign bus.busy_o           = (state != S_IDLE);

endmodule
